basic_op_server: RTL

//  Responder side of the shared-arithmetic interface used by the encoder FSMs (div_s, Chebps, LSP, ...).

---
 rtl/basic_op_server_pkg.sv | 46 ++++
 rtl/basic_op_server_alu.sv | 39 +++
 rtl/basic_op_server.sv | 117 +++++++++++
 3 files changed

// File: rtl/basic_op_server_pkg.sv
// rtl/basic_op_server_pkg.sv - opcodes, saturation limits and clamp helpers for the shared basic-op unit
package basic_op_server_pkg;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_L_ADD  = 3'd2;
    localparam logic [2:0] OP_L_SUB  = 3'd3;
    localparam logic [2:0] OP_MULT   = 3'd4;
    localparam logic [2:0] OP_L_MULT = 3'd5;
    localparam logic [2:0] OP_NEGATE = 3'd6;

    localparam logic [31:0] MAX_16 = 32'h0000_7FFF;
    localparam logic [31:0] MIN_16 = 32'hFFFF_8000;
    localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_32 = 32'h8000_0000;

    typedef enum logic {ST_IDLE, ST_SERVE} state_t;

    typedef struct packed {
        logic        ovf;
        logic [31:0] val;
    } alu_out_t;

    // 16-bit results are returned sign-extended to 32 bits
    function automatic alu_out_t sat16(input logic signed [32:0] v);
        alu_out_t r;
        if (v > 33'sd32767)
            r = '{ovf: 1'b1, val: MAX_16};
        else if (v < -33'sd32768)
            r = '{ovf: 1'b1, val: MIN_16};
        else
            r = '{ovf: 1'b0, val: v[31:0]};
        return r;
    endfunction

    // 33-bit value from a 32-bit add/sub or a doubled product; bits 32/31 disagree on overflow
    function automatic alu_out_t sat32(input logic signed [32:0] v);
        alu_out_t r;
        if (v[32] != v[31])
            r = '{ovf: 1'b1, val: (v[32] ? MIN_32 : MAX_32)};
        else
            r = '{ovf: 1'b0, val: v[31:0]};
        return r;
    endfunction

endpackage

// File: rtl/basic_op_server_alu.sv
// rtl/basic_op_server_alu.sv - combinational G.729 saturating basic-op datapath
module basic_op_server_alu
    import basic_op_server_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic        ovf
);

    logic signed [32:0] a16x, b16x, a32x, b32x;
    logic signed [31:0] pa, pb, prod, prod_sh;
    alu_out_t           r;

    always_comb begin
        a16x    = {{17{a[15]}}, a[15:0]};
        b16x    = {{17{b[15]}}, b[15:0]};
        a32x    = {a[31], a};
        b32x    = {b[31], b};
        pa      = {{16{a[15]}}, a[15:0]};
        pb      = {{16{b[15]}}, b[15:0]};
        prod    = pa * pb;
        prod_sh = prod >>> 15;
        case (op)
            OP_ADD:    r = sat16(a16x + b16x);
            OP_SUB:    r = sat16(a16x - b16x);
            OP_L_ADD:  r = sat32(a32x + b32x);
            OP_L_SUB:  r = sat32(a32x - b32x);
            OP_MULT:   r = sat16({prod_sh[31], prod_sh});
            OP_L_MULT: r = sat32({prod, 1'b0});
            OP_NEGATE: r = sat16(33'sd0 - a16x);
            default:   r = '0;
        endcase
        res = r.val;
        ovf = r.ovf;
    end

endmodule

// File: rtl/basic_op_server.sv
// rtl/basic_op_server.sv - round-robin arbiter sharing one saturating basic-op unit among N clients
module basic_op_server
    import basic_op_server_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [3*N-1:0]    op,
    input  logic [32*N-1:0]   opa,
    input  logic [32*N-1:0]   opb,
    output logic [N-1:0]      grant,
    output logic [31:0]       result,
    output logic [N-1:0]      rvalid,
    output logic              ovf,
    output logic              ovf_stky
);

    state_t             state, state_n;
    logic [N-1:0]       grant_n;
    logic [PTR_W-1:0]   ptr, ptr_n, own, own_n, pick;
    logic               found, fire;
    logic [2:0]         cur_op;
    logic [31:0]        cur_a, cur_b, alu_res;
    logic               alu_ovf;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N)
            s = s - N;
        return PTR_W'(s);
    endfunction

    // Scan from the farthest offset down so the requester nearest ptr wins
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) begin
                found = 1'b1;
                pick  = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        cur_op = op[int'(own) * 3 +: 3];
        cur_a  = opa[int'(own) * 32 +: 32];
        cur_b  = opb[int'(own) * 32 +: 32];
    end

    basic_op_server_alu u_alu (
        .op  (cur_op),
        .a   (cur_a),
        .b   (cur_b),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    always_comb begin
        state_n = state;
        grant_n = grant;
        own_n   = own;
        ptr_n   = ptr;
        fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    own_n         = pick;
                    state_n       = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (req[own]) begin
                    fire = 1'b1;
                end else begin
                    grant_n = '0;
                    ptr_n   = wrap_add(own, 1);
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            own      <= '0;
            ptr      <= '0;
            result   <= '0;
            rvalid   <= '0;
            ovf      <= 1'b0;
            ovf_stky <= 1'b0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            own    <= own_n;
            ptr    <= ptr_n;
            rvalid <= '0;
            ovf    <= 1'b0;
            if (fire) begin
                result      <= alu_res;
                rvalid[own] <= 1'b1;
                ovf         <= alu_ovf;
                ovf_stky    <= ovf_stky | alu_ovf;
            end
        end
    end

endmodule
